// File: rtl/sdf_r2_stage_if.sv
// Streaming bus of one radix-2 SDF FFT stage: sample in/out plus the twiddle ROM lookup.
interface sdf_r2_stage_if #(
   parameter int LOG2N = 10,
   parameter int DW    = 16,
   parameter int TW    = 16
);
   logic                    in_valid;
   logic signed [DW-1:0]    in_re;
   logic signed [DW-1:0]    in_im;
   logic        [LOG2N-2:0] tw_addr;
   logic signed [TW-1:0]    tw_re;
   logic signed [TW-1:0]    tw_im;
   logic                    out_valid;
   logic signed [DW-1:0]    out_re;
   logic signed [DW-1:0]    out_im;

   modport master (
      output in_valid, in_re, in_im, tw_re, tw_im,
      input  tw_addr, out_valid, out_re, out_im
   );

   modport slave (
      input  in_valid, in_re, in_im, tw_re, tw_im,
      output tw_addr, out_valid, out_re, out_im
   );
endinterface

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-delay-feedback DIF FFT stage with stall support, optional 1/2 scaling,
// saturation and an external twiddle ROM; chain LOG2N of these with STAGE = 1..LOG2N.
module sdf_r2_stage #(
   parameter int LOG2N = 10,
   parameter int STAGE = 1,
   parameter int DW    = 16,
   parameter int TW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          scale_en,
   sdf_r2_stage_if.slave bus
);
   localparam int D  = 1 << (LOG2N - STAGE);
   localparam int CW = LOG2N - STAGE + 1;
   localparam int JW = (CW > 1) ? CW - 1 : 1;
   localparam int AW = LOG2N - 1;
   localparam int MW = DW + TW + 1;
   localparam int SW = DW + 2;
   localparam int PW = DW + TW;

   typedef logic signed [DW-1:0] data_t;

   localparam logic signed [MW-1:0] RND = MW'(1) <<< (TW - 3);

   function automatic data_t sat_dw(input logic signed [MW-1:0] x);
      if ((&x[MW-1:DW-1]) || !(|x[MW-1:DW-1]))
         return x[DW-1:0];
      else if (x[MW-1])
         return {1'b1, {(DW-1){1'b0}}};
      else
         return {1'b0, {(DW-1){1'b1}}};
   endfunction

   // Halving rounds half up and can never leave the DW range; otherwise clip.
   function automatic data_t scale_or_sat(input logic signed [SW-1:0] s, input logic halve);
      logic signed [SW-1:0] r;
      r = s + SW'(1);
      r = r >>> 1;
      return halve ? r[DW-1:0] : sat_dw(MW'(s));
   endfunction

   function automatic data_t round_prod(input logic signed [MW-1:0] p);
      logic signed [MW-1:0] r;
      r = (p + RND) >>> (TW - 2);
      return sat_dw(r);
   endfunction

   logic [CW-1:0] cnt_q, cnt_d;
   logic          primed_q, primed_d;
   logic          out_valid_q, out_valid_d;
   data_t         out_re_q, out_re_d;
   data_t         out_im_q, out_im_d;
   data_t         dl_re_q [D];
   data_t         dl_im_q [D];
   data_t         dl_wr_re_d, dl_wr_im_d;

   logic          accept;
   logic          phase;
   logic [JW-1:0] j;
   data_t         head_re, head_im;

   logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [MW-1:0] prod_re, prod_im;

   assign accept  = bus.in_valid && !clr;
   assign phase   = cnt_q[CW-1];
   assign j       = JW'(cnt_q & CW'(D - 1));
   assign head_re = dl_re_q[j];
   assign head_im = dl_im_q[j];

   // Only meaningful in phase 0; last stage always addresses W^0.
   assign bus.tw_addr = AW'(j) << (STAGE - 1);

   assign sum_re = SW'(head_re) + SW'(bus.in_re);
   assign sum_im = SW'(head_im) + SW'(bus.in_im);
   assign dif_re = SW'(head_re) - SW'(bus.in_re);
   assign dif_im = SW'(head_im) - SW'(bus.in_im);

   assign p_rr    = head_re * bus.tw_re;
   assign p_ii    = head_im * bus.tw_im;
   assign p_ri    = head_re * bus.tw_im;
   assign p_ir    = head_im * bus.tw_re;
   assign prod_re = MW'(p_rr) - MW'(p_ii);
   assign prod_im = MW'(p_ri) + MW'(p_ir);

   always_comb begin
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      out_valid_d = 1'b0;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      dl_wr_re_d  = bus.in_re;
      dl_wr_im_d  = bus.in_im;
      if (clr) begin
         cnt_d    = '0;
         primed_d = 1'b0;
      end else if (bus.in_valid) begin
         cnt_d = cnt_q + 1'b1;
         if (phase) begin
            primed_d    = 1'b1;
            out_valid_d = 1'b1;
            out_re_d    = scale_or_sat(sum_re, scale_en);
            out_im_d    = scale_or_sat(sum_im, scale_en);
            dl_wr_re_d  = scale_or_sat(dif_re, scale_en);
            dl_wr_im_d  = scale_or_sat(dif_im, scale_en);
         end else if (primed_q) begin
            // Head holds the difference written one half-frame ago.
            out_valid_d = 1'b1;
            out_re_d    = round_prod(prod_re);
            out_im_d    = round_prod(prod_im);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
      end
   end

   // Delay line is deliberately unreset; stale words are masked by the prime flag.
   always_ff @(posedge clk) begin
      if (accept) begin
         dl_re_q[j] <= dl_wr_re_d;
         dl_im_q[j] <= dl_wr_im_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_re    = out_re_q;
   assign bus.out_im    = out_im_q;
endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage: a D=4 first stage and a D=1 last stage of an 8-point FFT share one stimulus stream.
module tb_sdf_r2_stage;
   localparam int LOG2N = 3;
   localparam int DW    = 16;
   localparam int TW    = 16;
   localparam int ONE   = 1 << (TW - 2);
   localparam int MAXV  = (1 << (DW - 1)) - 1;
   localparam int MINV  = -(1 << (DW - 1));

   typedef struct {
      int re;
      int im;
   } cplx_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic clr = 1'b0;
   logic scale_en = 1'b0;
   logic s_v = 1'b0;
   logic signed [DW-1:0] s_re = '0;
   logic signed [DW-1:0] s_im = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdf_r2_stage_if #(.LOG2N(LOG2N), .DW(DW), .TW(TW)) if_a ();
   sdf_r2_stage_if #(.LOG2N(LOG2N), .DW(DW), .TW(TW)) if_b ();

   sdf_r2_stage #(.LOG2N(LOG2N), .STAGE(1), .DW(DW), .TW(TW)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .scale_en(scale_en), .bus(if_a.slave));
   sdf_r2_stage #(.LOG2N(LOG2N), .STAGE(3), .DW(DW), .TW(TW)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .scale_en(scale_en), .bus(if_b.slave));

   function automatic int rom_re(input int k);
      return int'(real'(ONE) * $cos(6.283185307179586 * real'(k) / real'(1 << LOG2N)));
   endfunction

   function automatic int rom_im(input int k);
      return int'(-real'(ONE) * $sin(6.283185307179586 * real'(k) / real'(1 << LOG2N)));
   endfunction

   assign if_a.in_valid = s_v;
   assign if_a.in_re    = s_re;
   assign if_a.in_im    = s_im;
   assign if_a.tw_re    = TW'(rom_re(int'(if_a.tw_addr)));
   assign if_a.tw_im    = TW'(rom_im(int'(if_a.tw_addr)));
   assign if_b.in_valid = s_v;
   assign if_b.in_re    = s_re;
   assign if_b.in_im    = s_im;
   assign if_b.tw_re    = TW'(rom_re(int'(if_b.tw_addr)));
   assign if_b.tw_im    = TW'(rom_im(int'(if_b.tw_addr)));

   // ---------------- reference model ----------------
   cplx_t dq0[$];
   cplx_t dq1[$];
   cplx_t cap_a[$];
   cplx_t cap_b[$];
   int m_pos[2];
   int m_prim[2];
   int ev[2];
   int er[2];
   int ei[2];

   function automatic int dd(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   function automatic int stg(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   function automatic int sat(input int x);
      if (x > MAXV) return MAXV;
      if (x < MINV) return MINV;
      return x;
   endfunction

   function automatic int addsub_m(input int s, input bit halve);
      return halve ? ((s + 1) >>> 1) : sat(s);
   endfunction

   function automatic int rprod(input longint p);
      longint r;
      r = (p + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
      if (r > MAXV) return MAXV;
      if (r < MINV) return MINV;
      return int'(r);
   endfunction

   task automatic model_accept(input int u, input int re, input int im, input bit sc);
      cplx_t h, w;
      int d, p, k;
      d = dd(u);
      p = m_pos[u];
      if (u == 0) h = dq0.pop_front(); else h = dq1.pop_front();
      if (p < d) begin
         w.re = re;
         w.im = im;
         ev[u] = m_prim[u];
         if (m_prim[u] != 0) begin
            k = p << (stg(u) - 1);
            er[u] = rprod(longint'(h.re) * rom_re(k) - longint'(h.im) * rom_im(k));
            ei[u] = rprod(longint'(h.re) * rom_im(k) + longint'(h.im) * rom_re(k));
         end
      end else begin
         ev[u] = 1;
         er[u] = addsub_m(h.re + re, sc);
         ei[u] = addsub_m(h.im + im, sc);
         w.re  = addsub_m(h.re - re, sc);
         w.im  = addsub_m(h.im - im, sc);
         m_prim[u] = 1;
      end
      if (u == 0) dq0.push_back(w); else dq1.push_back(w);
      m_pos[u] = (p + 1) % (2 * d);
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int u = 0; u < 2; u++) begin
         if (!rst_n) begin
            m_pos[u] = 0; m_prim[u] = 0; ev[u] = 0; er[u] = 0; ei[u] = 0;
         end else if (clr) begin
            m_pos[u] = 0; m_prim[u] = 0; ev[u] = 0;
         end else if (s_v) begin
            model_accept(u, int'(s_re), int'(s_im), scale_en);
         end else begin
            ev[u] = 0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic cmp_unit(input int u, input logic v, input logic signed [DW-1:0] r,
                           input logic signed [DW-1:0] i, input logic [LOG2N-2:0] ta);
      cplx_t c;
      int exp_ta;
      checks++;
      if ($isunknown({v, r, i}) || int'(v) != ev[u] || int'(r) != er[u] || int'(i) != ei[u]) begin
         errors++;
         $display("FAIL out_unit%0d t=%0t actual v=%0b re=%0d im=%0d required v=%0d re=%0d im=%0d",
                  u, $time, v, r, i, ev[u], er[u], ei[u]);
      end
      if (rst_n && m_pos[u] < dd(u)) begin
         exp_ta = m_pos[u] << (stg(u) - 1);
         checks++;
         if ($isunknown(ta) || int'(ta) != exp_ta) begin
            errors++;
            $display("FAIL tw_addr_unit%0d t=%0t actual=%0d required=%0d", u, $time, ta, exp_ta);
         end
      end
      if (v === 1'b1) begin
         c.re = int'(r);
         c.im = int'(i);
         if (u == 0) cap_a.push_back(c); else cap_b.push_back(c);
      end
   endtask

   task automatic cmp_all();
      cmp_unit(0, if_a.out_valid, if_a.out_re, if_a.out_im, if_a.tw_addr);
      cmp_unit(1, if_b.out_valid, if_b.out_re, if_b.out_im, if_b.tw_addr);
   endtask

   task automatic lit(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic lit_near(input string nm, input int act, input int req);
      checks++;
      if (act > req + 1 || act < req - 1) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d+-1", nm, act, req);
      end
   endtask

   task automatic step(input bit v, input int re, input int im);
      s_v  = v;
      s_re = DW'(re);
      s_im = DW'(im);
      @(negedge clk);
      cmp_all();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step(1'b0, 0, 0);
      clr = 1'b0;
   endtask

   int rr[16];
   int ri[16];
   bit rs[16];
   cplx_t ref_q[$];

   initial begin
      for (int k = 0; k < 4; k++) dq0.push_back('{0, 0});
      dq1.push_back('{0, 0});
      #1 rst_n = 1'b0;
      repeat (3) step(1'b0, 0, 0);
      lit("reset_a_valid", int'(if_a.out_valid), 0);
      lit("reset_a_re", int'(if_a.out_re), 0);
      lit("reset_b_im", int'(if_b.out_im), 0);
      rst_n = 1'b1;

      // Last stage butterfly: (5,0),(3,0) -> (8,0) then (2,0)
      step(1'b1, 5, 0);
      lit("b_first_no_valid", int'(if_b.out_valid), 0);
      step(1'b1, 3, 0);
      lit("b_sum_valid", int'(if_b.out_valid), 1);
      lit("b_sum_re", int'(if_b.out_re), 8);
      step(1'b1, 0, 0);
      lit("b_dif_re", int'(if_b.out_re), 2);
      lit("b_dif_im", int'(if_b.out_im), 0);
      step(1'b0, 0, 0);

      // First stage on x0..x3 = 1000, x4..x7 = 0
      do_clr();
      cap_a.delete();
      for (int k = 0; k < 8; k++) step(1'b1, (k < 4) ? 1000 : 0, 0);
      for (int k = 0; k < 4; k++) begin
         lit("a_tw_addr_seq", int'(if_a.tw_addr), k);
         step(1'b1, 0, 0);
      end
      step(1'b0, 0, 0);
      lit("a_impulse_count", cap_a.size(), 8);
      for (int k = 0; k < 4; k++) lit("a_sum_re", cap_a[k].re, 1000);
      lit("a_w0_re", cap_a[4].re, 1000);
      lit("a_w0_im", cap_a[4].im, 0);
      lit_near("a_w1_re", cap_a[5].re, 707);
      lit_near("a_w1_im", cap_a[5].im, -707);
      lit_near("a_w2_im", cap_a[6].im, -1000);
      lit_near("a_w3_re", cap_a[7].re, -707);

      // Saturation on the last stage
      for (int m = 0; m < 3; m++) begin
         do_clr();
         cap_b.delete();
         scale_en = (m != 0);
         step(1'b1, (m == 2) ? MINV : MAXV, (m == 2) ? MINV : 0);
         step(1'b1, (m == 2) ? MINV : MAXV, (m == 2) ? MINV : 0);
         step(1'b1, 0, 0);
         step(1'b0, 0, 0);
         lit("sat_count", cap_b.size(), 2);
         lit("sat_sum_re", cap_b[0].re, (m == 2) ? MINV : MAXV);
         lit("sat_sum_im", cap_b[0].im, (m == 2) ? MINV : 0);
         lit("sat_dif_re", cap_b[1].re, 0);
      end
      scale_en = 1'b0;

      // Stalled stream must equal the gap-free stream
      for (int k = 0; k < 16; k++) begin
         rr[k] = int'($signed(DW'($urandom)));
         ri[k] = int'($signed(DW'($urandom)));
         rs[k] = 1'($urandom);
      end
      for (int run = 0; run < 2; run++) begin
         do_clr();
         cap_a.delete();
         for (int k = 0; k < 20; k++) begin
            if (run == 1) repeat ($urandom_range(0, 3)) step(1'b0, 0, 0);
            scale_en = (k < 16) ? rs[k] : 1'b0;
            step(1'b1, (k < 16) ? rr[k] : 0, (k < 16) ? ri[k] : 0);
         end
         step(1'b0, 0, 0);
         if (run == 0) ref_q = cap_a;
      end
      lit("stall_count", cap_a.size(), ref_q.size());
      for (int k = 0; k < ref_q.size() && k < cap_a.size(); k++) begin
         lit("stall_re", cap_a[k].re, ref_q[k].re);
         lit("stall_im", cap_a[k].im, ref_q[k].im);
      end

      // Reset mid-frame at sample 3
      do_clr();
      for (int k = 0; k < 3; k++) step(1'b1, 100 + k, -50);
      s_v = 1'b1; s_re = 16'sd400; s_im = 16'sd0;
      @(negedge clk);
      cmp_all();
      rst_n = 1'b0;
      #1;
      lit("midrst_a_valid", int'(if_a.out_valid), 0);
      lit("midrst_a_re", int'(if_a.out_re), 0);
      lit("midrst_b_re", int'(if_b.out_re), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cap_a.delete();
      for (int k = 0; k < 4; k++) step(1'b1, 10 * k, 3);
      step(1'b0, 0, 0);
      lit("midrst_no_valid", cap_a.size(), 0);
      for (int k = 0; k < 4; k++) step(1'b1, -7 * k, 11);

      // clr mid-frame drops the sample presented with it
      do_clr();
      step(1'b1, 1, 2);
      step(1'b1, 3, 4);
      clr = 1'b1;
      step(1'b1, 999, 999);
      clr = 1'b0;
      lit("clr_a_valid", int'(if_a.out_valid), 0);
      lit("clr_b_valid", int'(if_b.out_valid), 0);
      for (int k = 0; k < 12; k++) step(1'b1, int'($signed(DW'($urandom))), int'($signed(DW'($urandom))));

      // Random soak with stalls, scaling changes and rare clears
      for (int k = 0; k < 600; k++) begin
         scale_en = 1'($urandom);
         clr = ($urandom_range(0, 63) == 0);
         step($urandom_range(0, 3) != 0, int'($signed(DW'($urandom))), int'($signed(DW'($urandom))));
      end
      clr = 1'b0;
      step(1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
